// File: rtl/output_reader.sv
// output_reader
//   Buffers results from the compute write path in an 8-entry circular
//   store and streams them to a consumer over valid/ready. Words are grouped
//   into frames of FRAME_LEN; the last word of a frame is flagged and a
//   one-cycle pulse follows its acceptance.
//
// Ports
//   Clock       system clock, rising edge
//   Res_o_read  synchronous reset, active low
//   Wr_en       writer presents a result this cycle
//   Wr_data     result word
//   Wr_full     registered: buffer holds 8 words, writes are dropped
//   O_valid     O_data holds a valid word
//   O_ready     consumer accepts the word this cycle
//   O_data      streamed word
//   O_last      O_data is the final word of its frame
//   Frame_done  one-cycle pulse after the last word of a frame is accepted
//   Ovf_err     sticky: a write was attempted while full
module output_reader #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic              Clock,
    input  logic              Res_o_read,
    input  logic              Wr_en,
    input  logic [DATA_W-1:0] Wr_data,
    output logic              Wr_full,
    output logic              O_valid,
    input  logic              O_ready,
    output logic [DATA_W-1:0] O_data,
    output logic              O_last,
    output logic              Frame_done,
    output logic              Ovf_err
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic [DATA_W-1:0] r_mem [8];
    logic [2:0]        r_wptr;
    logic [2:0]        r_rptr;
    logic [3:0]        r_occ;
    logic              r_full;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [BEAT_W-1:0] r_beat;
    logic              r_done;
    logic              r_ovf;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_done_nxt;

    logic              w_wr;
    logic              w_load;
    logic              w_hs;
    logic              w_last;
    logic [3:0]        w_occ_nxt;

    // Fullness is judged on the registered flag, so a read freeing an entry
    // in the same cycle does not rescue a write attempted while full.
    assign w_wr      = Wr_en & ~r_full;
    assign w_load    = (~r_valid | O_ready) & (r_occ != 4'd0);
    assign w_hs      = r_valid & O_ready;
    assign w_last    = r_valid & (r_beat == LAST_BEAT);
    assign w_occ_nxt = r_occ + {3'b000, w_wr} - {3'b000, w_load};

    // Storage needs no reset: the pointers and occupancy define its content.
    always_ff @(posedge Clock) begin
        if (Res_o_read && w_wr) begin
            r_mem[r_wptr] <= Wr_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Res_o_read) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_beat  <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (Wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == 4'd8);

            if (w_load) begin
                r_data  <= r_mem[r_rptr];
                r_valid <= 1'b1;
                r_rptr  <= r_rptr + 3'd1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end

            // Beat tracks the word currently in the output register.
            if (w_hs) begin
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
            end

            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Res_o_read) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // A load on the frame-closing edge is beat 0 of the next
                // frame, so back-to-back frames stay in STREAM.
                if (w_hs && w_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = w_load ? S_STREAM : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Wr_full    = r_full;
    assign O_valid    = r_valid;
    assign O_data     = r_data;
    assign O_last     = w_last;
    assign Frame_done = r_done;
    assign Ovf_err    = r_ovf;

endmodule
